hs32_mem_align: RTL and testbench

Bus initiator that sits between the HS32 CPU memory port and any word-aligned memory slave (BRAM/SRAM controllers, MMIO). It accepts one byte-addressed 32-bit load/store from the CPU and issues either one or two aligned word transactions downstream. Each transaction carries byte-lane enables. Read beats are merged and write data is split so the CPU sees a single unaligned-capable access.

---
 rtl/hs32_mem_pkg.sv | 44 ++++
 rtl/hs32_mem_align_if.sv | 33 +++
 rtl/hs32_lane_shift.sv | 20 ++
 rtl/hs32_mem_align.sv | 142 ++++++++++++++
 tb/tb_hs32_mem_align.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hs32_mem_pkg.sv
// Shared types and lane helpers for the HS32 memory aligner.
//   state_e          : aligner FSM states
//   mask_first/second: byte enables for the first/second downstream beat
//   mask_to_bits     : expands a lane mask to a 32-bit bit mask
package hs32_mem_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = DATA_W / LANE_W;

  // Lane 0 (byte offset 0) sits in the most significant byte of a word.
  localparam int unsigned LANE0_LSB = DATA_W - LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef logic [NUM_LANES-1:0] mask_t;
  typedef logic [DATA_W-1:0]    word_t;

  // Lanes at and after byte offset k within the first word.
  function automatic mask_t mask_first(input logic [1:0] k);
    return mask_t'(4'b1111 >> k);
  endfunction

  // Remaining lanes, which spill into the following word.
  function automatic mask_t mask_second(input logic [1:0] k);
    return ~mask_first(k);
  endfunction

  // Mask bit (NUM_LANES-1-lane) enables lane `lane`.
  function automatic word_t mask_to_bits(input mask_t m);
    word_t bits;
    bits = '0;
    for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
      bits[LANE0_LSB - lane*LANE_W +: LANE_W] = {LANE_W{m[NUM_LANES-1-lane]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/hs32_mem_align_if.sv
// Downstream word-aligned memory bus.
//   maddr   : word address (bits [1:0] zero)
//   mrw     : 1 = write
//   mdwrite : lane-aligned write data
//   mmask   : byte enables, bit 3 = bits 31:24
//   mstb    : request, held until mack
//   mdread  : read data, valid with mack
//   mack    : acknowledge
interface hs32_mem_align_if
  import hs32_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] maddr;
  logic                  mrw;
  word_t                 mdwrite;
  mask_t                 mmask;
  logic                  mstb;
  word_t                 mdread;
  logic                  mack;

  modport master (
    output maddr, mrw, mdwrite, mmask, mstb,
    input  mdread, mack
  );

  modport slave (
    input  maddr, mrw, mdwrite, mmask, mstb,
    output mdread, mack
  );

endinterface

// File: rtl/hs32_lane_shift.sv
// Byte-lane funnel shift: data_o = upper word of ({hi_i, lo_i} << 8*amt_i).
//   hi_i, lo_i : source words (hi_i supplies the result's leading lanes)
//   amt_i      : shift in whole lanes (0..3)
//   data_o     : combinational result
// With hi_i == lo_i this is a lane rotate-left.
module hs32_lane_shift
  import hs32_mem_pkg::*;
(
  input  word_t      hi_i,
  input  word_t      lo_i,
  input  logic [1:0] amt_i,
  output word_t      data_o
);

  logic [2*DATA_W-1:0] funnel;

  assign funnel = {hi_i, lo_i} << {amt_i, 3'b000};
  assign data_o = funnel[2*DATA_W-1 -: DATA_W];

endmodule

// File: rtl/hs32_mem_align.sv
// HS32 memory aligner: turns one byte-addressed 32-bit CPU access into one
// (aligned) or two (unaligned) word transactions with byte enables.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_addr, i_rw, i_dwrite, i_stb : CPU request, accepted when !o_busy
//   o_dread, o_ack : merged load data and one-cycle completion pulse
//   o_busy         : request in flight
//   mbus           : downstream word bus (master side)
module hs32_mem_align
  import hs32_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rw,
  input  word_t                 i_dwrite,
  input  logic                  i_stb,
  output word_t                 o_dread,
  output logic                  o_ack,
  output logic                  o_busy,
  hs32_mem_align_if.master      mbus
);

  localparam int unsigned WA_W = ADDR_WIDTH - 2;

  state_e            state_q;
  logic [1:0]        k_q;
  logic [WA_W-1:0]   waddr_q;
  word_t             wrot_q;
  word_t             d1_q;

  logic [1:0]        wamt_c;
  word_t             wrot_c;
  word_t             merge_c;
  logic              accept_c;

  // Rotating store data right by k lanes lines up both beats at once;
  // each beat then keeps only its own lanes.
  assign wamt_c = 2'(3'd4 - 3'(i_addr[1:0]));

  hs32_lane_shift u_wr_rot (
    .hi_i   (i_dwrite),
    .lo_i   (i_dwrite),
    .amt_i  (wamt_c),
    .data_o (wrot_c)
  );

  // (d1 << 8k) | (d2 >> 8(4-k)); the second beat arrives on mdread.
  hs32_lane_shift u_rd_merge (
    .hi_i   (d1_q),
    .lo_i   (mbus.mdread),
    .amt_i  (k_q),
    .data_o (merge_c)
  );

  assign accept_c = i_stb && !o_busy && (state_q == IDLE);

  // Aligner FSM with registered CPU and bus outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      waddr_q      <= '0;
      wrot_q       <= '0;
      d1_q         <= '0;
      o_dread      <= '0;
      o_ack        <= 1'b0;
      o_busy       <= 1'b0;
      mbus.maddr   <= '0;
      mbus.mrw     <= 1'b0;
      mbus.mdwrite <= '0;
      mbus.mmask   <= '0;
      mbus.mstb    <= 1'b0;
    end else begin
      o_ack <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q      <= BEAT1;
            k_q          <= i_addr[1:0];
            waddr_q      <= i_addr[ADDR_WIDTH-1:2];
            wrot_q       <= wrot_c;
            o_busy       <= 1'b1;
            mbus.maddr   <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            mbus.mrw     <= i_rw;
            mbus.mmask   <= mask_first(i_addr[1:0]);
            mbus.mdwrite <= i_rw ? (wrot_c & mask_to_bits(mask_first(i_addr[1:0])))
                                 : '0;
            mbus.mstb    <= 1'b1;
          end
        end

        BEAT1: begin
          if (mbus.mack) begin
            d1_q <= mbus.mdread;
            if (k_q == 2'd0) begin
              state_q      <= RESP;
              o_ack        <= 1'b1;
              o_dread      <= mbus.mrw ? '0 : mbus.mdread;
              mbus.maddr   <= '0;
              mbus.mmask   <= '0;
              mbus.mdwrite <= '0;
              mbus.mstb    <= 1'b0;
            end else begin
              // mstb stays high; address wraps with the word counter.
              state_q      <= BEAT2;
              mbus.maddr   <= {waddr_q + WA_W'(1), 2'b00};
              mbus.mmask   <= mask_second(k_q);
              mbus.mdwrite <= mbus.mrw ? (wrot_q & mask_to_bits(mask_second(k_q)))
                                       : '0;
            end
          end
        end

        BEAT2: begin
          if (mbus.mack) begin
            state_q      <= RESP;
            o_ack        <= 1'b1;
            o_dread      <= mbus.mrw ? '0 : merge_c;
            mbus.maddr   <= '0;
            mbus.mmask   <= '0;
            mbus.mdwrite <= '0;
            mbus.mstb    <= 1'b0;
          end
        end

        RESP: begin
          state_q  <= IDLE;
          o_dread  <= '0;
          o_busy   <= 1'b0;
          mbus.mrw <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_mem_align.sv
// Directed bench for hs32_mem_align with a behavioural wait-state slave.
module tb_hs32_mem_align;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_addr;
  logic        i_rw;
  logic [31:0] i_dwrite;
  logic        i_stb;
  logic [31:0] o_dread;
  logic        o_ack;
  logic        o_busy;

  hs32_mem_align_if #(.ADDR_WIDTH(32)) mbus ();

  hs32_mem_align #(.ADDR_WIDTH(32)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_addr   (i_addr),
    .i_rw     (i_rw),
    .i_dwrite (i_dwrite),
    .i_stb    (i_stb),
    .o_dread  (o_dread),
    .o_ack    (o_ack),
    .o_busy   (o_busy),
    .mbus     (mbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Slave configuration and beat log.
  int          wait_n  = 0;
  int          wcnt    = 0;
  logic [31:0] rd_a1   = 32'h0;
  logic [31:0] rd_w1   = 32'h0;
  logic [31:0] rd_w2   = 32'h0;
  int          nbeats  = 0;
  int          ack_cnt = 0;
  int          gap_cnt = 0;
  logic [31:0] b_addr [8];
  logic [3:0]  b_mask [8];
  logic [31:0] b_data [8];
  logic        b_rw   [8];

  initial begin
    mbus.mack   = 1'b0;
    mbus.mdread = 32'h0;
  end

  // Slave acks after wait_n idle cycles of each beat; mstb staying high
  // right after an ack is the next beat.
  always @(negedge clk) begin
    if (o_ack) ack_cnt++;
    if (o_busy && !o_ack && !mbus.mstb) gap_cnt++;
    if (!mbus.mstb) begin
      mbus.mack = 1'b0;
      wcnt = 0;
    end else begin
      if (mbus.mack) wcnt = 0;
      mbus.mack = 1'b0;
      if (wcnt == wait_n) begin
        mbus.mack   = 1'b1;
        mbus.mdread = (mbus.maddr == rd_a1) ? rd_w1 : rd_w2;
        if (nbeats < 8) begin
          b_addr[nbeats] = mbus.maddr;
          b_mask[nbeats] = mbus.mmask;
          b_data[nbeats] = mbus.mdwrite;
          b_rw[nbeats]   = mbus.mrw;
        end
        nbeats++;
      end else begin
        wcnt++;
      end
    end
  end

  // Issue one request; lat counts edges from accept to the edge ending o_ack.
  task automatic run_req(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                         input int waits, input bit stray,
                         output int lat, output logic [31:0] rdata);
    bit seen;
    seen    = 1'b0;
    lat     = 0;
    rdata   = 32'h0;
    wait_n  = waits;
    nbeats  = 0;
    ack_cnt = 0;
    gap_cnt = 0;
    @(negedge clk);
    i_addr   = addr;
    i_rw     = rw;
    i_dwrite = wdata;
    i_stb    = 1'b1;
    @(posedge clk);
    #1;
    i_stb = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      if (stray) begin
        i_stb  = (lat == 2);
        i_addr = 32'h0000_0400;
      end
      seen = o_ack;
      if (seen) rdata = o_dread;
      @(posedge clk);
      lat++;
    end
    #1;
    i_stb = 1'b0;
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  int          lat;
  logic [31:0] rdata;
  int          cnt;

  initial begin
    i_reset  = 1'b1;
    i_addr   = 32'h0;
    i_rw     = 1'b0;
    i_dwrite = 32'h0;
    i_stb    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   32'(o_ack), 32'd0);
    check("rst_busy",  32'(o_busy), 32'd0);
    check("rst_mstb",  32'(mbus.mstb), 32'd0);
    check("rst_maddr", mbus.maddr, 32'h0);
    check("rst_mmask", 32'(mbus.mmask), 32'h0);
    check("rst_dread", o_dread, 32'h0);
    @(negedge clk);
    i_reset = 1'b0;

    // Aligned read
    rd_a1 = 32'h100; rd_w1 = 32'hAABBCCDD; rd_w2 = 32'h0;
    run_req(32'h100, 1'b0, 32'h0, 0, 1'b0, lat, rdata);
    check("al_lat",   32'(lat), 32'd2);
    check("al_beats", 32'(nbeats), 32'd1);
    check("al_addr",  b_addr[0], 32'h100);
    check("al_mask",  32'(b_mask[0]), 32'hF);
    check("al_data",  rdata, 32'hAABBCCDD);

    // Unaligned read, k=1
    rd_a1 = 32'h100; rd_w1 = 32'h11223344; rd_w2 = 32'h55667788;
    run_req(32'h101, 1'b0, 32'h0, 0, 1'b0, lat, rdata);
    check("ur_lat",   32'(lat), 32'd3);
    check("ur_beats", 32'(nbeats), 32'd2);
    check("ur_addr0", b_addr[0], 32'h100);
    check("ur_mask0", 32'(b_mask[0]), 32'h7);
    check("ur_addr1", b_addr[1], 32'h104);
    check("ur_mask1", 32'(b_mask[1]), 32'h8);
    check("ur_data",  rdata, 32'h22334455);

    // Unaligned write, k=3
    run_req(32'h203, 1'b1, 32'hA1B2C3D4, 0, 1'b0, lat, rdata);
    check("uw_lat",   32'(lat), 32'd3);
    check("uw_addr0", b_addr[0], 32'h200);
    check("uw_mask0", 32'(b_mask[0]), 32'h1);
    check("uw_data0", b_data[0], 32'h000000A1);
    check("uw_rw0",   32'(b_rw[0]), 32'd1);
    check("uw_addr1", b_addr[1], 32'h204);
    check("uw_mask1", 32'(b_mask[1]), 32'hE);
    check("uw_data1", b_data[1], 32'hB2C3D400);
    check("uw_rw1",   32'(b_rw[1]), 32'd1);
    check("uw_dread", rdata, 32'h0);

    // Wait states on k=2 with a stray strobe while busy
    rd_a1 = 32'h300; rd_w1 = 32'h01020304; rd_w2 = 32'h05060708;
    run_req(32'h302, 1'b0, 32'h0, 3, 1'b1, lat, rdata);
    check("ws_lat",   32'(lat), 32'd9);
    check("ws_data",  rdata, 32'h03040506);
    check("ws_gap",   32'(gap_cnt), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("ws_beats", 32'(nbeats), 32'd2);
    check("ws_acks",  32'(ack_cnt), 32'd1);
    check("ws_idle",  32'(o_busy), 32'd0);

    // Address wrap-around, k=2
    rd_a1 = 32'hFFFFFFFC; rd_w1 = 32'hDEADBEEF; rd_w2 = 32'hCAFEF00D;
    run_req(32'hFFFFFFFE, 1'b0, 32'h0, 0, 1'b0, lat, rdata);
    check("wr_addr0", b_addr[0], 32'hFFFFFFFC);
    check("wr_mask0", 32'(b_mask[0]), 32'h3);
    check("wr_addr1", b_addr[1], 32'h00000000);
    check("wr_mask1", 32'(b_mask[1]), 32'hC);
    check("wr_data",  rdata, 32'hBEEFCAFE);

    // Reset during BEAT2
    rd_a1 = 32'h100; rd_w1 = 32'h11223344; rd_w2 = 32'h55667788;
    wait_n = 3; nbeats = 0;
    @(negedge clk);
    i_addr = 32'h101; i_rw = 1'b0; i_stb = 1'b1;
    @(posedge clk);
    #1;
    i_stb = 1'b0;
    cnt = 0;
    while (nbeats < 1 && cnt < 40) begin
      @(posedge clk);
      cnt++;
    end
    check("rm_beat1", 32'(nbeats), 32'd1);
    @(negedge clk);
    check("rm_b2addr", mbus.maddr, 32'h104);
    ack_cnt = 0;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check("rm_ack",    32'(o_ack), 32'd0);
    check("rm_busy",   32'(o_busy), 32'd0);
    check("rm_mstb",   32'(mbus.mstb), 32'd0);
    check("rm_maddr",  mbus.maddr, 32'h0);
    check("rm_mmask",  32'(mbus.mmask), 32'h0);
    check("rm_mdwr",   mbus.mdwrite, 32'h0);
    check("rm_mrw",    32'(mbus.mrw), 32'd0);
    check("rm_dread",  o_dread, 32'h0);
    @(negedge clk);
    i_reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rm_noack", 32'(ack_cnt), 32'd0);

    // Fresh aligned write with one wait state after reset
    run_req(32'h500, 1'b1, 32'h12345678, 1, 1'b0, lat, rdata);
    check("pr_lat",  32'(lat), 32'd3);
    check("pr_addr", b_addr[0], 32'h500);
    check("pr_mask", 32'(b_mask[0]), 32'hF);
    check("pr_data", b_data[0], 32'h12345678);
    check("pr_rw",   32'(b_rw[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
